rv_fifo: RTL and testbench
==========================

Name: rv_fifo

Overview:
- Synchronous single-clock FIFO with ready/valid handshakes on both the write side and the read side.
- Buffers DATA_DEPTH words of DATA_WIDTH bits between a producer and a consumer.
- First-word-fall-through: the head word is presented on data_out whenever valid_out is high.
- Also reports occupancy (count) and the empty/full flags for flow control and debug.

Parameters:
- DATA_WIDTH, 16, width of each stored word in bits.
- DATA_DEPTH, 16, number of entries; must be a power of two and at least 2.
- LB_DATA_DEPTH, $clog2(DATA_DEPTH), derived localparam; not overridable.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous active-low reset; state is cleared while rst=0.
- data_in  input  DATA_WIDTH  write data.
- valid_in  input  1  producer offers data_in this cycle.
- ready_in  output  1  FIFO can accept a word (equals !full).
- data_out  output  DATA_WIDTH  head-of-queue word.
- valid_out  output  1  data_out holds a valid word (equals !empty).
- ready_out  input  1  consumer accepts data_out this cycle.
- count  output  LB_DATA_DEPTH+1  current occupancy, range 0..DATA_DEPTH.
- empty  output  1  count==0.
- full  output  1  count==DATA_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - Read/write pointers and count go to 0.
  - Outputs become empty=1, full=0, ready_in=1, valid_out=0.
  - Memory contents are not cleared.
- Push:
  - Occurs on a rising clk when valid_in && ready_in.
  - mem[wr_ptr] <= data_in; wr_ptr advances by 1.
- Pop:
  - Occurs on a rising clk when valid_out && ready_out.
  - rd_ptr advances by 1.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged when push and pop happen together, or when neither happens.
- Pointers:
  - LB_DATA_DEPTH+1 bits wide; the low bits address memory and wrap naturally from DATA_DEPTH-1 to 0.
  - The MSB distinguishes full from empty.
  - count may equivalently be derived as wr_ptr - rd_ptr.
- data_out:
  - Driven combinationally as mem[rd_ptr[LB_DATA_DEPTH-1:0]].
  - Before the edge that pops it, data_out shows the oldest unpopped word; after the pop, the next word appears with no added latency.
  - When empty, data_out is stale and don't-care, but it must not be X after any prior write to that slot.
- Latency:
  - A word pushed at edge N is visible on data_out with valid_out=1 after edge N, provided it is at the head.
  - Flags and count update at the same edge as the push or pop.
- Full boundary:
  - ready_in=0, so valid_in is ignored and neither memory nor count changes.
  - A simultaneous pop is still performed: count goes to DATA_DEPTH-1.
- Empty boundary:
  - valid_out=0, so ready_out is ignored.
  - A simultaneous push is performed: count goes to 1.
  - There is no bypass, so data_out becomes valid only after the edge.
- ready_in and valid_out depend only on registered state, never combinationally on valid_in or ready_out.
- Reset mid-operation:
  - Immediately empties the FIFO regardless of the handshake inputs.
  - Any pending push or pop on that edge is discarded.

Test Plan:
- Reset: hold rst=0 for 10 cycles, then release -> ready_in=1, valid_out=0, empty=1, full=0, count=0.
- Fill: push 16 random 16-bit values on consecutive cycles with ready_out=0 -> count=16, full=1, ready_in=0, valid_out=1, data_out equals the first pushed value.
- Overflow: with the FIFO full, drive valid_in=1 with 0xBEEF for 3 cycles -> count stays 16; the subsequent drain contains no 0xBEEF.
- Drain: hold ready_out=1 for 16 cycles -> data_out at each edge matches the pushed values in FIFO order; afterwards count=0, empty=1, valid_out=0, and a 17th cycle pops nothing.
- Simultaneous push/pop and wrap:
  - Prefill 3 words, then push and pop every cycle for 40 cycles (pointers wrap twice).
  - count remains 3 throughout and output order matches a reference queue.
  - Repeat the check at full (count 16 -> 15) and at empty (count 0 -> 1).
- Mid-operation reset: with 5 words queued, pulse rst=0 between clock edges -> outputs clear immediately (count=0, empty=1, ready_in=1) without waiting for clk.

Source files
------------

// File: rtl/rv_fifo.sv
// Single-clock first-word-fall-through FIFO with ready/valid on both sides.
// Occupancy and the full/empty flags come from two wrap-bit pointers.
module rv_fifo #(
    parameter  int DATA_WIDTH    = 16,
    parameter  int DATA_DEPTH    = 16,
    localparam int LB_DATA_DEPTH = $clog2(DATA_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_in,
    output logic                    ready_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [LB_DATA_DEPTH:0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam logic [LB_DATA_DEPTH:0] PTR_ONE = {{LB_DATA_DEPTH{1'b0}}, 1'b1};

    logic [LB_DATA_DEPTH:0]  r_wr_ptr;
    logic [LB_DATA_DEPTH:0]  r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_mem [DATA_DEPTH];
    logic                    w_push;
    logic                    w_pop;

    // Equal low bits with differing wrap bits means the writer is a full lap ahead.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[LB_DATA_DEPTH] != r_rd_ptr[LB_DATA_DEPTH]) &&
                       (r_wr_ptr[LB_DATA_DEPTH-1:0] == r_rd_ptr[LB_DATA_DEPTH-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign ready_in  = !full;
    assign valid_out = !empty;

    assign w_push = valid_in  && ready_in;
    assign w_pop  = valid_out && ready_out;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // NOTE: storage has no reset; contents are only meaningful behind valid_out, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[LB_DATA_DEPTH-1:0]] <= data_in;
        end
    end

    assign data_out = r_mem[r_rd_ptr[LB_DATA_DEPTH-1:0]];

endmodule

// File: tb/tb_rv_fifo.sv
// Self-checking bench for rv_fifo: a vector table for the basic handshakes, then
// directed fill/overflow/drain/wrap/reset sequences checked against a reference queue.
module tb_rv_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_out;
    logic [4:0]    count;
    logic          empty;
    logic          full;

    rv_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          vin;
        logic [DW-1:0] din;
        logic          rout;
        int            exp_count;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_beef  = 0;
    logic [DW-1:0] sb [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus. The reference queue decides whether a push/pop happens,
    // popped words are compared before the edge, and occupancy is compared after it.
    task automatic cycle(input logic vin, input logic [DW-1:0] din, input logic rout);
        logic          do_push;
        logic          do_pop;
        logic [DW-1:0] exp;
        valid_in  = vin;
        data_in   = din;
        ready_out = rout;
        do_pop  = rout && (sb.size() > 0);
        do_push = vin && (sb.size() < DEPTH);
        if (do_pop) begin
            exp = sb.pop_front();
            if (data_out == 16'hBEEF) n_beef++;
            check("pop_data", {16'h0, data_out}, {16'h0, exp});
        end
        if (do_push) sb.push_back(din);
        @(posedge clk);
        #1;
        check("count_vs_model", {27'h0, count}, sb.size());
    endtask

    task automatic check_flags(input string tag, input int c, input logic e, input logic f);
        check({tag, "_count"},     {27'h0, count}, c);
        check({tag, "_empty"},     {31'h0, empty}, {31'h0, e});
        check({tag, "_full"},      {31'h0, full}, {31'h0, f});
        check({tag, "_ready_in"},  {31'h0, ready_in}, {31'h0, !f});
        check({tag, "_valid_out"}, {31'h0, valid_out}, {31'h0, !e});
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        v = DW'($urandom_range(0, 16'hFFFF));
        if (v == 16'hBEEF) v = 16'h1234;
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1'b1, 16'h1111, 1'b0, 1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h2222, 1'b0, 2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 16'h3333, 1'b1, 2, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 2, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 16'h4444, 1'b1, 1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 0, 1'b1, 1'b0};

        rst = 1'b0; valid_in = 1'b0; data_in = '0; ready_out = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_flags("reset", 0, 1'b1, 1'b0);

        // Vector table: basic push, pop, simultaneous, and pop-on-empty.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].vin, vecs[i].din, vecs[i].rout);
            check_flags($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_empty, vecs[i].exp_full);
        end

        // Fill with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, rnd(), 1'b0);
        check_flags("fill", 16, 1'b0, 1'b1);
        check("fill_head", {16'h0, data_out}, {16'h0, sb[0]});

        // Overflow attempts must be ignored.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hBEEF, 1'b0);
        check_flags("overflow", 16, 1'b0, 1'b1);

        // Drain in order, then one extra pop cycle on empty.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1);
        check_flags("drain", 0, 1'b1, 1'b0);
        check("no_beef", n_beef, 0);
        cycle(1'b0, '0, 1'b1);
        check_flags("extra_pop", 0, 1'b1, 1'b0);

        // Steady push+pop at occupancy 3 across two pointer wraps.
        for (int i = 0; i < 3; i++) cycle(1'b1, rnd(), 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, rnd(), 1'b1);
        check_flags("wrap", 3, 1'b0, 1'b0);

        // At full, the push is blocked but the pop still happens.
        for (int i = 0; i < DEPTH - 3; i++) cycle(1'b1, rnd(), 1'b0);
        check_flags("prefull", 16, 1'b0, 1'b1);
        cycle(1'b1, 16'hBEEF, 1'b1);
        check_flags("full_pushpop", 15, 1'b0, 1'b0);

        // At empty, the pop is ignored but the push happens.
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, '0, 1'b1);
        check_flags("preempty", 0, 1'b1, 1'b0);
        cycle(1'b1, 16'hA5A5, 1'b1);
        check_flags("empty_pushpop", 1, 1'b0, 1'b0);
        check("empty_pushpop_data", {16'h0, data_out}, 32'hA5A5);
        cycle(1'b0, '0, 1'b1);

        // Asynchronous reset mid-operation with handshakes active.
        for (int i = 0; i < 5; i++) cycle(1'b1, rnd(), 1'b0);
        check_flags("prereset", 5, 1'b0, 1'b0);
        #2;
        valid_in = 1'b1; ready_out = 1'b1;
        rst = 1'b0;
        #1;
        check_flags("async_reset", 0, 1'b1, 1'b0);
        sb.delete();
        @(posedge clk);
        #1;
        check_flags("reset_held_edge", 0, 1'b1, 1'b0);
        rst = 1'b1;
        valid_in = 1'b0; ready_out = 1'b0;
        cycle(1'b1, 16'h5A5A, 1'b0);
        check_flags("after_reset", 1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
